// File: rtl/sinegen_ctrl.sv
// sinegen_ctrl: phase-accumulator sequencer that shares one synchronous-read
// sine ROM (1-cycle latency) between two channels. Channel A follows the
// accumulator. Channel B is channel A plus a programmable offset in ROM
// entries. A new sample pair is produced every 3 cycles while en is high.
// Optional feature: define SINEGEN_WRAP_SYNC_EN to add the wrap_sync output.
// wrap_sync pulses with out_valid when the accumulator wraps.
module sinegen_ctrl #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int DATA_WIDTH    = 8,
  parameter int ACC_WIDTH     = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     cfg_valid,
  output logic                     cfg_ready,
  input  logic [ACC_WIDTH-1:0]     cfg_incr,
  input  logic [ADDRESS_WIDTH-1:0] cfg_offset,
  output logic [ADDRESS_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0]    rom_dout,
  output logic [DATA_WIDTH-1:0]    dout_a,
  output logic [DATA_WIDTH-1:0]    dout_b,
`ifdef SINEGEN_WRAP_SYNC_EN
  output logic                     wrap_sync,
`endif
  output logic                     out_valid
);

  // Reset step advances the ROM address by exactly one entry per sample.
  localparam logic [ACC_WIDTH-1:0] INCR_RST =
    {{(ACC_WIDTH-1){1'b0}}, 1'b1} << (ACC_WIDTH - ADDRESS_WIDTH);

  typedef enum logic [1:0] {IDLE, FETCH_A, FETCH_B, CAPTURE} state_t;

  state_t                   state, state_next;
  logic [ACC_WIDTH-1:0]     acc;
  logic [ACC_WIDTH-1:0]     incr_reg;
  logic [ADDRESS_WIDTH-1:0] offset_reg;
  logic [DATA_WIDTH-1:0]    a_hold;
  logic [ADDRESS_WIDTH-1:0] ph_a, ph_b;
  logic                     in_fetch_b, in_capture;
  logic                     cfg_take;

  assign ph_a     = acc[ACC_WIDTH-1 -: ADDRESS_WIDTH];
  // Channel B phase wraps modulo the ROM depth; the carry is dropped.
  assign ph_b     = ph_a + offset_reg;
  assign cfg_take = cfg_valid && cfg_ready;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic: one sample takes FETCH_A -> FETCH_B -> CAPTURE
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (en) state_next = FETCH_A;
      FETCH_A: state_next = FETCH_B;
      FETCH_B: state_next = CAPTURE;
      CAPTURE: state_next = en ? FETCH_A : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State-decoded outputs: ROM address mux, config ready, and datapath strobes
  always_comb begin
    rom_addr   = ph_a;
    cfg_ready  = 1'b0;
    in_fetch_b = 1'b0;
    in_capture = 1'b0;
    case (state)
      IDLE:    cfg_ready = 1'b1;
      FETCH_A: rom_addr  = ph_a;
      FETCH_B: begin
        rom_addr   = ph_b;
        in_fetch_b = 1'b1;
      end
      CAPTURE: begin
        cfg_ready  = 1'b1;
        in_capture = 1'b1;
      end
      default: ;
    endcase
  end

  // Configuration registers; a capture-cycle accept still steps acc with the old incr
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      incr_reg   <= INCR_RST;
      offset_reg <= '0;
    end else if (cfg_take) begin
      incr_reg   <= cfg_incr;
      offset_reg <= cfg_offset;
    end
  end

  // Sample datapath: hold channel A word, then publish both words and step phase
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc       <= '0;
      a_hold    <= '0;
      dout_a    <= '0;
      dout_b    <= '0;
      out_valid <= 1'b0;
`ifdef SINEGEN_WRAP_SYNC_EN
      wrap_sync <= 1'b0;
`endif
    end else begin
      out_valid <= in_capture;
`ifdef SINEGEN_WRAP_SYNC_EN
      wrap_sync <= 1'b0;
`endif
      if (in_fetch_b) a_hold <= rom_dout;
      if (in_capture) begin
        dout_a <= a_hold;
        dout_b <= rom_dout;
`ifdef SINEGEN_WRAP_SYNC_EN
        {wrap_sync, acc} <= {1'b0, acc} + {1'b0, incr_reg};
`else
        acc <= acc + incr_reg;
`endif
      end
    end
  end

endmodule
